// File: rtl/counter_user.sv
// rtl/counter_user.sv - user-side step indexer/checker for the sequence game.
// Optional per-press timeout enabled by defining USER_TIMEOUT_EN.
module counter_user #(
  parameter int SIZE        = 4,
  parameter int CODE_W      = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TMR_W       = 10
) (
  input  logic                   CLKHZ,
  input  logic                   R,
  input  logic                   E,
  input  logic [SIZE-1:0]        ROUND,
  input  logic [2**CODE_W-1:0]   BTN,
  input  logic [CODE_W-1:0]      EXP_CODE,
  output logic [SIZE-1:0]        SEQUSER,
  output logic                   busy_User,
  output logic                   end_User,
  output logic                   err_User,
  output logic                   timeout_User
);

  localparam int NBTN = 2**CODE_W;

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WAIT_PRESS   = 3'd1;
  localparam logic [2:0] WAIT_RELEASE = 3'd2;
  localparam logic [2:0] DONE         = 3'd3;
  localparam logic [2:0] ERROR        = 3'd4;

  logic [2:0]        r_state;
  logic [SIZE-1:0]   r_seq;
  logic [SIZE-1:0]   r_round_q;
  logic [NBTN-1:0]   r_btn_prev;
  logic [CODE_W-1:0] w_code;
  logic              w_onehot;
  logic              w_press;
  logic              w_tmo;

  always_comb begin
    w_code = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (BTN[i]) w_code = CODE_W'(i);
    end
  end

  // Only a clean single-button rising press counts; chords are silently ignored.
  assign w_onehot = (BTN != '0) && ((BTN & (BTN - NBTN'(1))) == '0);
  assign w_press  = w_onehot && (r_btn_prev == '0);

`ifdef USER_TIMEOUT_EN
  logic [TMR_W-1:0] r_tmr;
  logic             r_to;

  assign w_tmo = (r_tmr == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLKHZ) begin
    if (R) begin
      r_tmr <= '0;
      r_to  <= 1'b0;
    end else begin
      if (r_state != WAIT_PRESS) r_tmr <= '0;
      else                       r_tmr <= r_tmr + TMR_W'(1);
      r_to <= (r_state == WAIT_PRESS) && E && !w_press && w_tmo;
    end
  end

  assign timeout_User = r_to;
`else
  logic [TMR_W-1:0] w_unused_tmr;
  assign w_unused_tmr = TMR_W'(TIMEOUT_CYC);
  assign w_tmo        = 1'b0;
  assign timeout_User = 1'b0;
`endif

  always_ff @(posedge CLKHZ) begin
    if (R) begin
      r_state    <= IDLE;
      r_seq      <= '0;
      r_round_q  <= '0;
      r_btn_prev <= '0;
    end else begin
      r_btn_prev <= BTN;
      case (r_state)
        IDLE: begin
          if (E) begin
            r_round_q <= ROUND;
            r_seq     <= '0;
            r_state   <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!E) begin
            r_seq   <= '0;
            r_state <= IDLE;
          end else if (w_press) begin
            r_state <= (w_code == EXP_CODE) ? WAIT_RELEASE : ERROR;
          end else if (w_tmo) begin
            r_state <= ERROR;
          end
        end
        WAIT_RELEASE: begin
          if (!E) begin
            r_seq   <= '0;
            r_state <= IDLE;
          end else if (BTN == '0) begin
            if (r_seq == r_round_q) begin
              r_state <= DONE;
            end else begin
              r_seq   <= r_seq + SIZE'(1);
              r_state <= WAIT_PRESS;
            end
          end
        end
        DONE, ERROR: begin
          r_seq   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_seq   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign SEQUSER   = r_seq;
  assign busy_User = (r_state == WAIT_PRESS) || (r_state == WAIT_RELEASE);
  assign end_User  = (r_state == DONE);
  assign err_User  = (r_state == ERROR);

endmodule

// File: tb/tb_counter_user.sv
// tb/tb_counter_user.sv - scoreboard bench for counter_user.
// Timeout cases run only when USER_TIMEOUT_EN is defined.
module tb_counter_user;

  localparam int EV_END = 1;
  localparam int EV_ERR = 2;
  localparam int EV_TMO = 6;

  logic       clk;
  logic       R;
  logic       E;
  logic [3:0] ROUND;
  logic [3:0] BTN;
  logic [1:0] EXP_CODE;
  logic [3:0] SEQUSER;
  logic       busy_User;
  logic       end_User;
  logic       err_User;
  logic       timeout_User;

  logic [1:0] rom [16];
  int         exp_q [$];
  int         total;
  int         bad;

  assign EXP_CODE = rom[SEQUSER];

  counter_user #(
    .SIZE(4), .CODE_W(2), .TIMEOUT_CYC(8), .TMR_W(4)
  ) dut (
    .CLKHZ(clk), .R(R), .E(E), .ROUND(ROUND), .BTN(BTN), .EXP_CODE(EXP_CODE),
    .SEQUSER(SEQUSER), .busy_User(busy_User), .end_User(end_User),
    .err_User(err_User), .timeout_User(timeout_User)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Every pulse seen must match the oldest expected event; an empty queue expects none.
  always @(negedge clk) begin
    if (!R && (end_User || err_User || timeout_User)) begin
      int e;
      e = (exp_q.size() == 0) ? 0 : exp_q.pop_front();
      check("pulse", {29'b0, timeout_User, err_User, end_User}, e);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int code);
    BTN = 4'(1 << code);
    tick(1);
    BTN = 4'b0;
    tick(1);
  endtask

  task automatic start(input int rnd);
    ROUND = 4'(rnd);
    E = 1'b1;
    tick(1);
  endtask

  task automatic finish_round();
    E = 1'b0;
    tick(2);
    check("idle_seq", int'(SEQUSER), 0);
    check("idle_busy", int'(busy_User), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    R = 1'b1; E = 1'b0; BTN = 4'b0; ROUND = 4'd0;
    for (int i = 0; i < 16; i++) rom[i] = 2'd0;
    tick(2);
    check("rst_seq", int'(SEQUSER), 0);
    check("rst_outs", int'({busy_User, end_User, err_User, timeout_User}), 0);
    R = 1'b0;
    tick(1);

    // Correct 3-step round
    rom[0] = 2'd1; rom[1] = 2'd3; rom[2] = 2'd0;
    start(2);
    check("c_seq0", int'(SEQUSER), 0);
    check("c_busy", int'(busy_User), 1);
    press(1);
    check("c_seq1", int'(SEQUSER), 1);
    press(3);
    check("c_seq2", int'(SEQUSER), 2);
    exp_q.push_back(EV_END);
    press(0);
    finish_round();

    // Wrong press on step 1
    rom[0] = 2'd3; rom[1] = 2'd2;
    start(3);
    press(3);
    check("w_seq1", int'(SEQUSER), 1);
    exp_q.push_back(EV_ERR);
    BTN = 4'b0001;
    tick(1);
    E = 1'b0;
    BTN = 4'b0;
    tick(2);
    check("w_seq", int'(SEQUSER), 0);
    check("w_busy", int'(busy_User), 0);

    // Chord ignored, then abort after step 1, then held button across E rise
    rom[0] = 2'd2; rom[1] = 2'd1;
    start(1);
    BTN = 4'b0101;
    tick(2);
    check("inv_busy", int'(busy_User), 1);
    check("inv_seq", int'(SEQUSER), 0);
    BTN = 4'b0;
    tick(1);
    press(2);
    check("ab_seq1", int'(SEQUSER), 1);
    E = 1'b0;
    tick(1);
    check("ab_seq", int'(SEQUSER), 0);
    check("ab_busy", int'(busy_User), 0);
    BTN = 4'b0100;
    start(1);
    tick(2);
    BTN = 4'b0;
    tick(1);
    check("hold_seq", int'(SEQUSER), 0);
    check("hold_busy", int'(busy_User), 1);
    press(2);
    check("hold_seq1", int'(SEQUSER), 1);
    exp_q.push_back(EV_END);
    press(1);
    finish_round();

    // Reset mid-round
    rom[0] = 2'd0; rom[1] = 2'd1;
    start(3);
    press(0);
    check("r_seq1", int'(SEQUSER), 1);
    R = 1'b1;
    tick(1);
    check("r_seq", int'(SEQUSER), 0);
    check("r_outs", int'({busy_User, end_User, err_User, timeout_User}), 0);
    R = 1'b0;
    E = 1'b0;
    tick(1);

    // Single-step round
    rom[0] = 2'd3;
    start(0);
    exp_q.push_back(EV_END);
    press(3);
    finish_round();

    // Full 16-step round; ROUND changed after start must not matter
    for (int i = 0; i < 16; i++) rom[i] = 2'($urandom_range(0, 3));
    start(15);
    ROUND = 4'd0;
    for (int i = 0; i < 16; i++) begin
      check("full_seq", int'(SEQUSER), i);
      if (i == 15) exp_q.push_back(EV_END);
      press(int'(rom[i]));
    end
    finish_round();

`ifdef USER_TIMEOUT_EN
    rom[0] = 2'd1;
    start(0);
    exp_q.push_back(EV_TMO);
    tick(8);
    E = 1'b0;
    tick(2);
    check("to_seq", int'(SEQUSER), 0);
    start(0);
    tick(7);
    exp_q.push_back(EV_END);
    press(1);
    finish_round();
`endif

    tick(2);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
